divider_param: RTL and testbench
================================

# divider_param

Parametrised sequential restoring divider, the successor to the fixed 8-bit Type 2 divider in the datapath. It divides a WIDTH-bit dividend by a WIDTH-bit divisor, producing one quotient bit per clock. It uses the same Req/Done request-completion handshake, and adds a Busy indication, divide-by-zero detection and optional signed operation. It sits between the operand registers and the result bus, and is driven by the control unit or by a stimulus bench.

## Interface
- WIDTH, 8: operand and result width in bits; legal range 2..32.
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Req  input  1  start request; sampled on the rising edge.
- Operand1  input  WIDTH  dividend; captured on acceptance.
- Operand2  input  WIDTH  divisor; captured on acceptance.
- Signed  input  1  present only with DIVIDER_SIGNED_EN; 1 = two's-complement operands; captured on acceptance.
- Busy  output  1  high while a division is in progress.
- Done  output  1  high while a valid result is held.
- DivZero  output  1  high with Done when the captured divisor was 0.
- Quotient  output  WIDTH  registered quotient.
- Remainder  output  WIDTH  registered remainder.

## Operation
- States: IDLE, CALC, FIX (signed build only), DONE.
- Acceptance: Req=1 on an edge while in IDLE or DONE. On that edge:
  - Operand1, Operand2 and Signed are captured.
  - Done and DivZero clear.
  - Iteration counter loads WIDTH-1.
- Req while in CALC or FIX is ignored. It is not queued.
- Divide by zero (captured divisor = 0): go straight to DONE on the acceptance edge.
  - Quotient = all ones.
  - Remainder = Operand1.
  - DivZero = 1.
- CALC iteration, one per edge:
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor at WIDTH+1 bits.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
- When the counter reaches 0:
  - Unsigned: go to DONE.
  - Signed: go to FIX.
- FIX: negate the quotient if the operand signs differ; negate the remainder if the dividend was negative. Division truncates toward zero. FIX then goes to DONE.
- Signed operation works on magnitudes. For most-negative / -1, the quotient wraps to the most-negative value, the remainder is 0, and no flag is raised.
- Quotient and Remainder output registers update only on entry to DONE. They hold the previous result throughout CALC and FIX, and hold the current result in DONE until the next completion.
- DONE persists until the next accepted Req or Reset.

## Timing
- Reset asserted: state = IDLE immediately; Busy, Done, DivZero, Quotient and Remainder = 0. Reset takes effect mid-operation too; any partial result is discarded.
- Reset release: the first edge with Reset=0 may accept Req.
- Counting the acceptance edge as edge k:
  - Busy=1 from edge k until edge k+WIDTH (unsigned) or k+WIDTH+1 (signed).
  - Done=1 after edge k+WIDTH (unsigned) or k+WIDTH+1 (signed).
  - Divide by zero: Done=1 and Busy=0 after edge k.
- Busy and Done are never high together.
- Back-to-back: Req=1 on the edge where Done is high starts the next division. Done falls on that same edge, and results stay stable until the next completion.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- DIVIDER_SIGNED_EN defined:
  - Signed port exists.
  - FIX state is present.
  - Signed=1 selects two's-complement division with one extra cycle of latency.
  - Signed=0 behaves exactly as the unsigned build, with no FIX cycle.
- DIVIDER_SIGNED_EN undefined:
  - No Signed port and no FIX state.
  - Unsigned only, latency WIDTH cycles.

## Test plan
- WIDTH=8, Reset pulse mid-CALC (Operand1=200, Operand2=7) -> all outputs 0 immediately, IDLE; a following Req with 200/7 gives Quotient=28, Remainder=4, Done 8 edges after acceptance.
- WIDTH=8, 9/8 then 255/1 back-to-back, with Req held high on the Done cycle -> 1 r 1, then 255 r 0; Done drops for exactly 8 cycles between the two results.
- WIDTH=8, Operand2=0, Operand1=77 -> Done and DivZero high after the acceptance edge, Quotient=255, Remainder=77, Busy never high.
- WIDTH=8, Req pulsed during CALC with new operands 10/3 -> ignored; the original result is delivered and Done latency is unchanged.
- WIDTH=16, 60000/123 -> Quotient=487, Remainder=99, Done 16 edges after acceptance.
- DIVIDER_SIGNED_EN, WIDTH=8, Signed=1:
  - -7/2 -> Quotient=-3, Remainder=-1, latency 9.
  - -128/-1 -> Quotient=-128, Remainder=0.

Source files
------------

// File: rtl/divider_param.sv
// rtl/divider_param.sv - parametrised sequential restoring divider with Req/Done handshake
//
// Purpose: divides a WIDTH-bit dividend by a WIDTH-bit divisor, one quotient
// bit per clock. Reports divide-by-zero and can optionally do signed division.
// Optional feature macro: DIVIDER_SIGNED_EN (adds i_signed and the FIX state).
//
// Ports:
//   i_clock      system clock, rising edge
//   i_reset      asynchronous active-high reset
//   i_req        start request, accepted in IDLE or DONE
//   i_operand1   dividend, captured on acceptance
//   i_operand2   divisor, captured on acceptance
//   i_signed     (DIVIDER_SIGNED_EN only) 1 = two's-complement operands
//   o_busy       division in progress
//   o_done       valid result held
//   o_div_zero   result came from a zero divisor
//   o_quotient   registered quotient
//   o_remainder  registered remainder

module divider_param #(
  parameter int WIDTH = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_req,
  input  logic [WIDTH-1:0] i_operand1,
  input  logic [WIDTH-1:0] i_operand2,
`ifdef DIVIDER_SIGNED_EN
  input  logic             i_signed,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_zero,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  localparam int CW = $clog2(WIDTH);

`ifdef DIVIDER_SIGNED_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2, S_DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd3} state_t;
`endif

  state_t           r_state;
  state_t           w_next_state;
  state_t           w_calc_exit;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rem;       // partial remainder
  logic [WIDTH-1:0] r_dvd;       // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0] r_dvs;
  logic             r_busy;
  logic             r_done;
  logic             r_div_zero;
  logic [WIDTH-1:0] r_quo_out;
  logic [WIDTH-1:0] r_rem_out;

  logic             w_accept;
  logic             w_zero;
  logic             w_last;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_qbit;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_dvd_next;
  logic [WIDTH-1:0] w_op1_mag;
  logic [WIDTH-1:0] w_op2_mag;

`ifdef DIVIDER_SIGNED_EN
  logic r_sgn;
  logic r_neg_q;
  logic r_neg_r;
  logic w_op1_neg;
  logic w_op2_neg;

  // Iterations always run on magnitudes; signs are re-applied in FIX.
  assign w_op1_neg   = i_signed & i_operand1[WIDTH-1];
  assign w_op2_neg   = i_signed & i_operand2[WIDTH-1];
  assign w_op1_mag   = w_op1_neg ? -i_operand1 : i_operand1;
  assign w_op2_mag   = w_op2_neg ? -i_operand2 : i_operand2;
  assign w_calc_exit = r_sgn ? S_FIX : S_DONE;
`else
  assign w_op1_mag   = i_operand1;
  assign w_op2_mag   = i_operand2;
  assign w_calc_exit = S_DONE;
`endif

  assign w_accept = i_req && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_zero   = (i_operand2 == '0);
  assign w_last   = (r_count == '0);

  // Trial subtract at WIDTH+1 bits; the top bit is the borrow (negative result).
  assign w_shift    = {r_rem, r_dvd[WIDTH-1]};
  assign w_trial    = w_shift - {1'b0, r_dvs};
  assign w_qbit     = ~w_trial[WIDTH];
  assign w_rem_next = w_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_dvd_next = {r_dvd[WIDTH-2:0], w_qbit};

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (w_accept) w_next_state = w_zero ? S_DONE : S_CALC;
      S_CALC:         if (w_last) w_next_state = w_calc_exit;
`ifdef DIVIDER_SIGNED_EN
      S_FIX:          w_next_state = S_DONE;
`endif
      default:        w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_count    <= '0;
      r_rem      <= '0;
      r_dvd      <= '0;
      r_dvs      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_quo_out  <= '0;
      r_rem_out  <= '0;
`ifdef DIVIDER_SIGNED_EN
      r_sgn      <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_rem   <= '0;
            r_dvd   <= w_op1_mag;
            r_dvs   <= w_op2_mag;
            r_count <= CW'(WIDTH - 1);
`ifdef DIVIDER_SIGNED_EN
            r_sgn   <= i_signed;
            r_neg_q <= w_op1_neg ^ w_op2_neg;
            r_neg_r <= w_op1_neg;
`endif
            if (w_zero) begin
              // Raw dividend is reported, regardless of signedness.
              r_quo_out  <= '1;
              r_rem_out  <= i_operand1;
              r_done     <= 1'b1;
              r_div_zero <= 1'b1;
              r_busy     <= 1'b0;
            end else begin
              r_done     <= 1'b0;
              r_div_zero <= 1'b0;
              r_busy     <= 1'b1;
            end
          end
        end
        S_CALC: begin
          r_rem   <= w_rem_next;
          r_dvd   <= w_dvd_next;
          r_count <= r_count - CW'(1);
          if (w_last && (w_calc_exit == S_DONE)) begin
            r_quo_out <= w_dvd_next;
            r_rem_out <= w_rem_next;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end
        end
`ifdef DIVIDER_SIGNED_EN
        S_FIX: begin
          r_quo_out <= r_neg_q ? -r_dvd : r_dvd;
          r_rem_out <= r_neg_r ? -r_rem : r_rem;
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
        end
`endif
        default: begin
        end
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_div_zero  = r_div_zero;
  assign o_quotient  = r_quo_out;
  assign o_remainder = r_rem_out;

endmodule

// File: tb/tb_divider_param.sv
// tb/tb_divider_param.sv - directed table-driven bench for divider_param
module tb_divider_param;

  typedef struct {
    logic [7:0] op1;
    logic [7:0] op2;
    logic       sg;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    string      nm;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        req;
  logic [7:0]  op1;
  logic [7:0]  op2;
  logic        sgn;
  logic        busy8, done8, dz8;
  logic [7:0]  q8, r8;

  logic        req16;
  logic [15:0] op1_16, op2_16;
  logic        busy16, done16, dz16;
  logic [15:0] q16, r16;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[$];

  divider_param #(.WIDTH(8)) dut8 (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_req       (req),
    .i_operand1  (op1),
    .i_operand2  (op2),
`ifdef DIVIDER_SIGNED_EN
    .i_signed    (sgn),
`endif
    .o_busy      (busy8),
    .o_done      (done8),
    .o_div_zero  (dz8),
    .o_quotient  (q8),
    .o_remainder (r8)
  );

  divider_param #(.WIDTH(16)) dut16 (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_req       (req16),
    .i_operand1  (op1_16),
    .i_operand2  (op2_16),
`ifdef DIVIDER_SIGNED_EN
    .i_signed    (1'b0),
`endif
    .o_busy      (busy16),
    .o_done      (done16),
    .o_div_zero  (dz16),
    .o_quotient  (q16),
    .o_remainder (r16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Issues one request on dut8 and follows it to Done. intrude_at >= 0 pulses
  // a second request with 10/3 at that cycle of the calculation.
  task automatic run_div(input vec_t v, input int intrude_at);
    logic [7:0] prev_q;
    logic [7:0] prev_r;
    int n;
    int exp_lat;
    exp_lat = v.dz ? 0 : (v.sg ? 9 : 8);
    prev_q = q8;
    prev_r = r8;
    op1 = v.op1; op2 = v.op2; sgn = v.sg; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    n = 0;
    while (!done8 && n < 40) begin
      chk({v.nm, " busy"}, busy8, 1'b1);
      chk({v.nm, " q hold"}, q8, prev_q);
      chk({v.nm, " r hold"}, r8, prev_r);
      if (n == intrude_at) begin
        op1 = 8'd10; op2 = 8'd3; req = 1'b1;
      end
      @(posedge clk); #1;
      req = 1'b0;
      n++;
    end
    chk({v.nm, " latency"}, n, exp_lat);
    chk({v.nm, " quotient"}, q8, v.q);
    chk({v.nm, " remainder"}, r8, v.r);
    chk({v.nm, " divzero"}, dz8, v.dz);
    chk({v.nm, " busy at done"}, busy8, 1'b0);
  endtask

  initial begin
    int n;
    vec_t v;
    rst = 1'b1; req = 1'b0; op1 = '0; op2 = '0; sgn = 1'b0;
    req16 = 1'b0; op1_16 = '0; op2_16 = '0;

    vecs.push_back('{8'd200, 8'd7,   1'b0, 8'd28,  8'd4,  1'b0, "200/7"});
    vecs.push_back('{8'd9,   8'd8,   1'b0, 8'd1,   8'd1,  1'b0, "9/8"});
    vecs.push_back('{8'd255, 8'd1,   1'b0, 8'd255, 8'd0,  1'b0, "255/1"});
    vecs.push_back('{8'd77,  8'd0,   1'b0, 8'd255, 8'd77, 1'b1, "77/0"});
    vecs.push_back('{8'd0,   8'd5,   1'b0, 8'd0,   8'd0,  1'b0, "0/5"});
    vecs.push_back('{8'd5,   8'd9,   1'b0, 8'd0,   8'd5,  1'b0, "5/9"});
    vecs.push_back('{8'd255, 8'd255, 1'b0, 8'd1,   8'd0,  1'b0, "255/255"});
    vecs.push_back('{8'd1,   8'd0,   1'b0, 8'd255, 8'd1,  1'b1, "1/0"});
    vecs.push_back('{8'd100, 8'd10,  1'b0, 8'd10,  8'd0,  1'b0, "100/10"});
`ifdef DIVIDER_SIGNED_EN
    vecs.push_back('{8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF, 1'b0, "s -7/2"});
    vecs.push_back('{8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0, "s -128/-1"});
    vecs.push_back('{8'h07, 8'hFE, 1'b1, 8'hFD, 8'h01, 1'b0, "s 7/-2"});
    vecs.push_back('{8'hF9, 8'hFE, 1'b1, 8'h03, 8'hFF, 1'b0, "s -7/-2"});
    vecs.push_back('{8'hF9, 8'h02, 1'b0, 8'd124, 8'd1, 1'b0, "u 249/2"});
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", busy8, 1'b0);
    chk("reset done", done8, 1'b0);
    chk("reset divzero", dz8, 1'b0);
    chk("reset quotient", q8, 8'd0);
    chk("reset remainder", r8, 8'd0);
    rst = 1'b0;

    // Consecutive entries run back-to-back: each request is raised on the
    // cycle the previous Done is observed.
    foreach (vecs[i]) run_div(vecs[i], -1);

    v = '{8'd100, 8'd7, 1'b0, 8'd14, 8'd2, 1'b0, "ignored req"};
    run_div(v, 3);

    // Reset in the middle of a calculation.
    op1 = 8'd200; op2 = 8'd7; sgn = 1'b0; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midreset busy", busy8, 1'b0);
    chk("midreset done", done8, 1'b0);
    chk("midreset divzero", dz8, 1'b0);
    chk("midreset quotient", q8, 8'd0);
    chk("midreset remainder", r8, 8'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    v = '{8'd200, 8'd7, 1'b0, 8'd28, 8'd4, 1'b0, "after reset 200/7"};
    run_div(v, -1);

    // WIDTH=16 instance.
    op1_16 = 16'd60000; op2_16 = 16'd123; req16 = 1'b1;
    @(posedge clk); #1;
    req16 = 1'b0;
    n = 0;
    while (!done16 && n < 60) begin
      chk("w16 busy", busy16, 1'b1);
      @(posedge clk); #1;
      n++;
    end
    chk("w16 latency", n, 16);
    chk("w16 quotient", q16, 16'd487);
    chk("w16 remainder", r16, 16'd99);
    chk("w16 divzero", dz16, 1'b0);
    chk("w16 busy at done", busy16, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
